// File: rtl/mips_pkg.sv
// Shared types for the MIPS data-side store buffer.
//   WORD_W      : data / byte-address width
//   word_t      : one data word
//   waddr_t     : word address (byte address with [1:0] dropped)
//   sb_entry_t  : one buffered store {word address, data}
package mips_pkg;

    localparam int unsigned WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [WORD_W-3:0] waddr_t;

    typedef struct packed {
        waddr_t addr;
        word_t  data;
    } sb_entry_t;

endpackage

// File: rtl/store_buffer_fifo.sv
// In-order FIFO of pending stores for the MIPS store buffer.
// Ports:
//   clk_i, rst_ni     : clock, synchronous active-low reset
//   push_i            : enqueue push_entry_i at the tail (caller guarantees ~full_o)
//   push_entry_i      : store to enqueue
//   pop_i             : dequeue the head (caller guarantees ~empty_o)
//   head_o            : oldest entry
//   full_o, empty_o   : occupancy flags
//   entries_o         : raw entry storage, indexed by physical slot
//   valid_o           : per-slot valid (slot holds a pending store)
//   age_o             : per-slot age relative to the head, 0 = oldest
module store_buffer_fifo
    import mips_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                                              clk_i,
    input  logic                                              rst_ni,
    input  logic                                              push_i,
    input  sb_entry_t                                         push_entry_i,
    input  logic                                              pop_i,
    output sb_entry_t                                         head_o,
    output logic                                              full_o,
    output logic                                              empty_o,
    output sb_entry_t [DEPTH-1:0]                             entries_o,
    output logic      [DEPTH-1:0]                             valid_o,
    output logic      [DEPTH-1:0][((DEPTH > 1) ? $clog2(DEPTH) : 1)-1:0] age_o
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    sb_entry_t [DEPTH-1:0] mem_q;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [PW:0]           count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // Pointers wrap naturally because DEPTH is a power of two.
        if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry contents are don't-care after reset, so the storage has no reset.
    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_ptr_q] <= push_entry_i;
    end

    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            age_o[i]   = PW'(i) - rd_ptr_q;
            valid_o[i] = ({1'b0, age_o[i]} < count_q);
        end
    end

    assign entries_o = mem_q;
    assign head_o    = mem_q[rd_ptr_q];
    assign full_o    = (count_q == (PW+1)'(DEPTH));
    assign empty_o   = (count_q == '0);

endmodule

// File: rtl/mips_store_buffer.sv
// Posted-write store buffer between the MIPS core data port and data memory.
// Stores are queued and drained in order over a valid/ready write port; loads
// read memory combinationally, with forwarding from the youngest matching
// buffered store. Word accesses only: aluout[1:0] is ignored.
// Ports:
//   clk, reset (sync, active-low)
//   memwrite, aluout, writedata : core store/load request
//   readdata                    : load data to core (combinational)
//   stall                       : store not accepted this cycle
//   mem_wvalid/mem_wready       : write handshake, mem_waddr/mem_wdata = head
//   mem_raddr/mem_rdata         : combinational read port
module mips_store_buffer
    import mips_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned WORD_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              memwrite,
    input  logic [WORD_W-1:0] aluout,
    input  logic [WORD_W-1:0] writedata,
    output logic [WORD_W-1:0] readdata,
    output logic              stall,
    output logic              mem_wvalid,
    input  logic              mem_wready,
    output logic [WORD_W-1:0] mem_waddr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic [WORD_W-1:0] mem_raddr,
    input  logic [WORD_W-1:0] mem_rdata
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    sb_entry_t             push_entry;
    sb_entry_t             head;
    sb_entry_t [DEPTH-1:0] entries;
    logic      [DEPTH-1:0] valid;
    logic      [DEPTH-1:0][PW-1:0] age;
    logic                  full, empty;
    logic                  enq, deq;

    logic                  fwd_hit;
    logic [PW-1:0]         fwd_age;
    word_t                 fwd_data;
    logic                  unused_lowbits;

    assign enq = memwrite & ~full;
    assign deq = mem_wvalid & mem_wready;

    // Depends only on registered occupancy; a store arriving when full waits
    // at least one cycle even if the head drains in that same cycle.
    assign stall = memwrite & full;

    assign push_entry.addr = aluout[WORD_W-1:2];
    assign push_entry.data = writedata;

    store_buffer_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk_i        (clk),
        .rst_ni       (reset),
        .push_i       (enq),
        .push_entry_i (push_entry),
        .pop_i        (deq),
        .head_o       (head),
        .full_o       (full),
        .empty_o      (empty),
        .entries_o    (entries),
        .valid_o      (valid),
        .age_o        (age)
    );

    assign mem_wvalid = ~empty;
    assign mem_waddr  = {head.addr, 2'b00};
    assign mem_wdata  = head.data;
    assign mem_raddr  = {aluout[WORD_W-1:2], 2'b00};

    // Youngest match = matching valid entry with the largest age. The head
    // keeps forwarding during the cycle it drains, since it is still valid.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_age  = '0;
        fwd_data = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (valid[i] && (entries[i].addr == aluout[WORD_W-1:2]) &&
                (!fwd_hit || (age[i] > fwd_age))) begin
                fwd_hit  = 1'b1;
                fwd_age  = age[i];
                fwd_data = entries[i].data;
            end
        end
    end

    assign readdata = fwd_hit ? fwd_data : mem_rdata;

    assign unused_lowbits = &{1'b0, aluout[1:0]};

endmodule

// File: tb/tb_mips_store_buffer.sv
module tb_mips_store_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        memwrite;
    logic [31:0] aluout;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        stall;
    logic        mem_wvalid;
    logic        mem_wready;
    logic [31:0] mem_waddr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_raddr;
    logic [31:0] mem_rdata;

    int unsigned tests_run = 0;
    int unsigned tests_failed = 0;

    logic [63:0] wq[$];

    always #5 clk = ~clk;

    mips_store_buffer #(
        .DEPTH (4),
        .WORD_W(32)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .memwrite  (memwrite),
        .aluout    (aluout),
        .writedata (writedata),
        .readdata  (readdata),
        .stall     (stall),
        .mem_wvalid(mem_wvalid),
        .mem_wready(mem_wready),
        .mem_waddr (mem_waddr),
        .mem_wdata (mem_wdata),
        .mem_raddr (mem_raddr),
        .mem_rdata (mem_rdata)
    );

    // Memory side: record every accepted write handshake (pre-edge values).
    always @(posedge clk) begin
        if (reset && mem_wvalid && mem_wready) wq.push_back({mem_waddr, mem_wdata});
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain_all(input int unsigned budget);
        int unsigned n = 0;
        mem_wready = 1'b1;
        #1;
        while (mem_wvalid && n < budget) begin
            tick();
            n++;
        end
        check("drain_timeout", {31'd0, mem_wvalid}, 32'd0);
        mem_wready = 1'b0;
        #1;
    endtask

    task automatic check_write(input string tag, input logic [31:0] a, input logic [31:0] d);
        logic [63:0] w;
        if (wq.size() == 0) begin
            check({tag, "_missing"}, 32'd0, 32'd1);
        end else begin
            w = wq.pop_front();
            check({tag, "_addr"}, w[63:32], a);
            check({tag, "_data"}, w[31:0], d);
        end
    endtask

    initial begin
        reset      = 1'b0;
        memwrite   = 1'b1;
        aluout     = 32'h40;
        writedata  = 32'h99;
        mem_wready = 1'b0;
        mem_rdata  = 32'h0;

        // 1. reset with a store request pending
        tick();
        tick();
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_wvalid", {31'd0, mem_wvalid}, 32'd0);
        reset    = 1'b1;
        memwrite = 1'b0;
        tick();
        tick();
        check("post_rst_wvalid", {31'd0, mem_wvalid}, 32'd0);
        check("post_rst_nowrite", wq.size(), 32'd0);

        // 2. single store, held until ready
        memwrite  = 1'b1;
        aluout    = 32'h40;
        writedata = 32'h11;
        #1;
        check("t2_wvalid_pre", {31'd0, mem_wvalid}, 32'd0);
        tick();
        memwrite = 1'b0;
        #1;
        check("t2_wvalid", {31'd0, mem_wvalid}, 32'd1);
        check("t2_waddr", mem_waddr, 32'h40);
        check("t2_wdata", mem_wdata, 32'h11);
        tick();
        tick();
        check("t2_hold_wvalid", {31'd0, mem_wvalid}, 32'd1);
        check("t2_hold_waddr", mem_waddr, 32'h40);
        check("t2_hold_wdata", mem_wdata, 32'h11);
        mem_wready = 1'b1;
        tick();
        mem_wready = 1'b0;
        #1;
        check("t2_empty", {31'd0, mem_wvalid}, 32'd0);
        check("t2_nwrites", wq.size(), 32'd1);
        check_write("t2_w", 32'h40, 32'h11);

        // 3. fill, stall, accept 5th after a drain
        for (int i = 0; i < 4; i++) begin
            memwrite  = 1'b1;
            aluout    = 32'(i * 4);
            writedata = 32'h100 + 32'(i);
            tick();
        end
        aluout    = 32'h10;
        writedata = 32'h104;
        #1;
        check("t3_stall_full", {31'd0, stall}, 32'd1);
        tick();
        check("t3_stall_still", {31'd0, stall}, 32'd1);
        mem_wready = 1'b1;
        #1;
        check("t3_stall_wready", {31'd0, stall}, 32'd1);
        tick();
        check("t3_accept", {31'd0, stall}, 32'd0);
        tick();
        memwrite = 1'b0;
        drain_all(20);
        check("t3_nwrites", wq.size(), 32'd5);
        for (int i = 0; i < 5; i++)
            check_write("t3_w", 32'(i * 4), 32'h100 + 32'(i));

        // 4. forwarding
        memwrite  = 1'b1;
        aluout    = 32'h80;
        writedata = 32'hA;
        tick();
        writedata = 32'hB;
        tick();
        memwrite  = 1'b0;
        mem_rdata = 32'h0;
        #1;
        check("t4_fwd_young", readdata, 32'hB);
        aluout = 32'h82;
        #1;
        check("t4_fwd_lowbits", readdata, 32'hB);
        check("t4_raddr", mem_raddr, 32'h80);
        aluout    = 32'h84;
        mem_rdata = 32'h55;
        #1;
        check("t4_miss", readdata, 32'h55);
        memwrite  = 1'b1;
        writedata = 32'hC;
        #1;
        check("t4_same_cycle", readdata, 32'h55);
        tick();
        memwrite = 1'b0;
        #1;
        check("t4_next_cycle", readdata, 32'hC);
        mem_wready = 1'b1;
        tick();
        tick();
        #1;
        check("t4_drain_fwd", readdata, 32'hC);
        tick();
        mem_wready = 1'b0;
        #1;
        check("t4_gone", readdata, 32'h55);
        check_write("t4_w0", 32'h80, 32'hA);
        check_write("t4_w1", 32'h80, 32'hB);
        check_write("t4_w2", 32'h84, 32'hC);

        // 5. concurrent enq/deq at count=2 across pointer wraps
        memwrite  = 1'b1;
        aluout    = 32'h200;
        writedata = 32'h20;
        tick();
        aluout    = 32'h204;
        writedata = 32'h21;
        tick();
        for (int k = 0; k < 10; k++) begin
            aluout     = 32'h208 + 32'(4 * k);
            writedata  = 32'h22 + 32'(k);
            mem_wready = 1'b1;
            #1;
            check("t5_stall", {31'd0, stall}, 32'd0);
            check("t5_head", mem_waddr, 32'h200 + 32'(4 * k));
            tick();
        end
        memwrite = 1'b0;
        tick();
        check("t5_one_left", {31'd0, mem_wvalid}, 32'd1);
        tick();
        check("t5_empty", {31'd0, mem_wvalid}, 32'd0);
        mem_wready = 1'b0;
        check("t5_nwrites", wq.size(), 32'd12);
        for (int j = 0; j < 12; j++)
            check_write("t5_w", 32'h200 + 32'(4 * j), 32'h20 + 32'(j));

        // 6. reset discards pending entries
        memwrite = 1'b1;
        for (int i = 0; i < 3; i++) begin
            aluout    = 32'h300 + 32'(4 * i);
            writedata = 32'(i + 1);
            tick();
        end
        memwrite = 1'b0;
        reset    = 1'b0;
        tick();
        check("t6_wvalid", {31'd0, mem_wvalid}, 32'd0);
        reset     = 1'b1;
        aluout    = 32'h300;
        mem_rdata = 32'h77;
        #1;
        check("t6_load0", readdata, 32'h77);
        aluout    = 32'h308;
        mem_rdata = 32'h78;
        #1;
        check("t6_load2", readdata, 32'h78);
        mem_wready = 1'b1;
        tick();
        tick();
        mem_wready = 1'b0;
        check("t6_nowrite", wq.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
